board_bringup_seq: RTL and testbench

BOARD_BRINGUP_SEQ -- requirements
Module: board_bringup_seq

---
 rtl/board_bringup_pkg.sv | 8 +
 rtl/bringup_timer.sv | 18 +
 rtl/board_bringup_seq.sv | 85 ++++++++
 tb/tb_board_bringup_seq.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/board_bringup_pkg.sv
// board_bringup_pkg: state encoding and widths shared by the board bring-up sequencer.
package board_bringup_pkg;
    localparam int CNT_W = 24;
    localparam int RETRY_W = 2;
    typedef enum logic [2:0] {
        STARTUP, START, WAIT_RISE, WAIT_DONE, SETTLE, MAC_RST, RUN, FAIL
    } state_t;
endpackage

// File: rtl/bringup_timer.sv
// bringup_timer: 24-bit cycle counter with clear; tc marks the last cycle of a limit-cycle delay.
module bringup_timer
    import board_bringup_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [CNT_W-1:0] limit,
    output logic             tc
);
    logic [CNT_W-1:0] count;
    always_ff @(posedge clk) begin
        if (rst || clr) count <= '0;
        else if (count != '1) count <= count + CNT_W'(1);
    end
    // comparing count+1 keeps a zero limit from stalling the state forever
    assign tc = ({1'b0, count} + (CNT_W+1)'(1)) >= {1'b0, limit};
endmodule

// File: rtl/board_bringup_seq.sv
// board_bringup_seq: powers up the Si570 via its init sequencer, retries failed passes,
// then releases the MAC reset once the clock has settled.
module board_bringup_seq
    import board_bringup_pkg::*;
#(
    parameter int unsigned STARTUP_CYCLES = 1024,
    parameter int unsigned SETTLE_CYCLES  = 500000,
    parameter int unsigned MAC_RST_CYCLES = 16,
    parameter int unsigned BUSY_TIMEOUT   = 1048576,
    parameter int unsigned MAX_RETRIES    = 3
) (
    input  logic               clk,
    input  logic               rst,
    output logic               init_start,
    input  logic               init_busy,
    input  logic               i2c_busy,
    input  logic               i2c_missed_ack,
    input  logic               reinit,
    output logic               mac_rst_n,
    output logic               done,
    output logic               error,
    output logic [RETRY_W-1:0] retry_count
);
    localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);

    state_t           state, state_next;
    logic             nack, fail_att, tc;
    logic [CNT_W-1:0] limit;

    assign limit = state == STARTUP ? CNT_W'(STARTUP_CYCLES) :
                   state == SETTLE  ? CNT_W'(SETTLE_CYCLES)  :
                   state == MAC_RST ? CNT_W'(MAC_RST_CYCLES) : CNT_W'(BUSY_TIMEOUT);

    bringup_timer timer (
        .clk   (clk),
        .rst   (rst),
        .clr   (state_next != state),
        .limit (limit),
        .tc    (tc)
    );

    always_comb begin
        state_next = state;
        fail_att = 1'b0;
        case (state)
            STARTUP:   if (tc) state_next = START;
            START:     state_next = WAIT_RISE;
            WAIT_RISE: if (init_busy) state_next = WAIT_DONE;
                       else if (tc) fail_att = 1'b1;
            // a NACK arriving together with completion still spoils the pass
            WAIT_DONE: if (!init_busy && !i2c_busy) begin
                           if (nack || i2c_missed_ack) fail_att = 1'b1;
                           else state_next = SETTLE;
                       end else if (tc) fail_att = 1'b1;
            SETTLE:    if (tc) state_next = MAC_RST;
            MAC_RST:   if (tc) state_next = RUN;
            RUN:       if (reinit) state_next = START;
            default:   state_next = FAIL;
        endcase
        if (fail_att) state_next = retry_count < MAX_R ? START : FAIL;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= STARTUP;
            nack        <= 1'b0;
            retry_count <= '0;
            init_start  <= 1'b0;
            mac_rst_n   <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            state       <= state_next;
            nack        <= state_next == START ? 1'b0 :
                           nack | (i2c_missed_ack && (state == WAIT_RISE || state == WAIT_DONE));
            retry_count <= state == RUN && state_next == START ? '0 :
                           fail_att && state_next == START ? retry_count + RETRY_W'(1) : retry_count;
            // outputs are registered from the next state so they line up with it
            init_start  <= state_next == START;
            mac_rst_n   <= state_next == RUN;
            done        <= state_next == RUN;
            error       <= state_next == FAIL;
        end
    end
endmodule

// File: tb/tb_board_bringup_seq.sv
// tb_board_bringup_seq: randomized bring-up scenarios scored against an event-level model
// (start pulses, entry to RUN, entry to FAIL) derived from the per-attempt timing rules.
module tb_board_bringup_seq;
    localparam int S_CYC = 8, SET_CYC = 20, MAC_CYC = 4, TMO = 100, MAXR = 3;
    typedef enum int {EV_START, EV_RUN, EV_FAIL} ev_t;
    typedef struct {ev_t kind; int gap; int retry;} exp_t;
    // per attempt, in cycles after the init_start cycle: busy rises at d for l cycles,
    // i2c_busy lingers e more, a NACK pulses at n (0 = none)
    typedef struct {int d; int l; int e; int n;} att_t;

    logic clk = 0, rst = 1, init_busy = 0, i2c_busy = 0, i2c_missed_ack = 0, reinit = 0;
    logic init_start, mac_rst_n, done, error;
    logic [1:0] retry_count;

    exp_t exp_q[$];
    att_t att[4];
    int checks = 0, errors = 0, cyc = 0, anchor = 0, npulse = 0, base = 0;
    bit reinit_req = 0, last_ok = 0, prev_mac = 0, prev_err = 0, in_run = 0, in_fail = 0;

    board_bringup_seq #(
        .STARTUP_CYCLES (S_CYC),
        .SETTLE_CYCLES  (SET_CYC),
        .MAC_RST_CYCLES (MAC_CYC),
        .BUSY_TIMEOUT   (TMO),
        .MAX_RETRIES    (MAXR)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .init_start     (init_start),
        .init_busy      (init_busy),
        .i2c_busy       (i2c_busy),
        .i2c_missed_ack (i2c_missed_ack),
        .reinit         (reinit),
        .mac_rst_n      (mac_rst_n),
        .done           (done),
        .error          (error),
        .retry_count    (retry_count)
    );

    always #5 clk = ~clk;

    function automatic int f_of(input att_t a);
        return a.d + a.l + a.e;
    endfunction

    // last cycle of the attempt spent waiting on the sequencer
    function automatic int last_wait(input att_t a);
        if (a.d > TMO) return TMO;
        return f_of(a) <= a.d + TMO ? f_of(a) : a.d + TMO;
    endfunction

    function automatic att_t gen();
        att_t a;
        int m, p;
        m = $urandom_range(0, 9);
        p = $urandom_range(0, 9);
        a.e = 0;
        if (m == 0) begin a.d = 1000; a.l = 1; end
        else if (m == 1) begin a.d = TMO; a.l = $urandom_range(1, 10); end
        else if (m == 2) begin a.d = $urandom_range(1, 5); a.l = $urandom_range(TMO - 5, TMO + 10); a.e = $urandom_range(0, 3); end
        else begin a.d = $urandom_range(1, 15); a.l = $urandom_range(1, 40); a.e = $urandom_range(0, 3); end
        a.n = p < 6 ? 0 : p < 8 ? $urandom_range(1, last_wait(a)) : last_wait(a);
        return a;
    endfunction

    task automatic plan(input int g0, input int r0);
        int gap, r;
        att_t a;
        bit ok;
        gap = g0;
        r = r0;
        base = npulse;
        last_ok = 0;
        for (int i = 0; i < 4; i++) begin
            a = att[i];
            ok = a.d <= TMO && f_of(a) <= a.d + TMO && a.n == 0;
            exp_q.push_back(exp_t'{EV_START, gap, r});
            if (ok) begin
                exp_q.push_back(exp_t'{EV_RUN, f_of(a) + 1 + SET_CYC + MAC_CYC, r});
                last_ok = 1;
                return;
            end
            if (r == MAXR) begin
                exp_q.push_back(exp_t'{EV_FAIL, last_wait(a) + 1, r});
                return;
            end
            r++;
            gap = last_wait(a) + 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, expv, cyc);
        end
    endtask

    task automatic ev(input ev_t k);
        exp_t x;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_event: got event %0d with none expected at cycle %0d", k, cyc);
        end else begin
            x = exp_q.pop_front();
            chk("event_kind", 32'(k), 32'(x.kind));
            chk("event_gap", 32'(cyc - anchor), 32'(x.gap));
            chk("retry_count", 32'(retry_count), 32'(x.retry));
        end
        if (k == EV_START) begin chk("start_outs", 32'({mac_rst_n, done, error}), 32'(0)); in_run = 0; end
        if (k == EV_RUN) begin chk("run_outs", 32'({done, error, init_start}), 32'(4)); in_run = 1; end
        if (k == EV_FAIL) begin chk("fail_outs", 32'({mac_rst_n, done, init_start}), 32'(0)); in_fail = 1; end
        anchor = cyc;
    endtask

    initial forever begin : monitor
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            chk("reset_outs", 32'({init_start, mac_rst_n, done, error, retry_count}), 32'(0));
            anchor = cyc;
            in_run = 0;
            in_fail = 0;
        end else begin
            if (init_start) ev(EV_START);
            if (mac_rst_n && !prev_mac) ev(EV_RUN);
            if (error && !prev_err) ev(EV_FAIL);
            if (in_run) chk("run_hold", 32'({mac_rst_n, done, error}), 32'(6));
            if (in_fail) chk("fail_hold", 32'({error, mac_rst_n, init_start}), 32'(4));
        end
        prev_mac = mac_rst_n;
        prev_err = error;
    end

    // plays the Si570 init sequencer and I2C master, keyed off each init_start pulse
    initial begin : pins
        int k, idx;
        att_t cur;
        k = 0;
        forever begin
            @(negedge clk);
            if (init_start) begin npulse++; k = 0; end
            else k++;
            idx = npulse - base - 1;
            if (idx >= 0 && idx < 4) begin
                cur = att[idx];
                init_busy = k >= cur.d && k < cur.d + cur.l;
                i2c_busy = k >= cur.d && k < cur.d + cur.l + cur.e;
                i2c_missed_ack = cur.n != 0 && k == cur.n;
            end else begin
                init_busy = 0;
                i2c_busy = 0;
                i2c_missed_ack = 0;
            end
            // stray reinit requests outside RUN must be ignored
            reinit = reinit_req || (!mac_rst_n && $urandom_range(0, 7) == 0);
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    task automatic drain(input int n);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < n) begin tick(1); t++; end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d events pending after %0d cycles", exp_q.size(), n);
            exp_q.delete();
        end
    endtask

    task automatic scenario(input bit do_reinit, input bit mid_rst);
        int j;
        tick(1);
        rst = 1;
        if (mid_rst) begin
            base = npulse;
            exp_q.push_back(exp_t'{EV_START, S_CYC, 0});
        end else plan(S_CYC, 0);
        tick(2);
        rst = 0;
        if (mid_rst) begin
            drain(200);
            tick(att[0].d + 5);
            return;
        end
        drain(3000);
        if (do_reinit && last_ok) begin
            j = $urandom_range(0, 5);
            for (int i = 0; i < 4; i++) att[i] = gen();
            plan(j + 1, 0);
            tick(j);
            reinit_req = 1;
            tick(1);
            reinit_req = 0;
            drain(3000);
        end
        tick(30);
    endtask

    initial begin : stim
        for (int i = 0; i < 4; i++) att[i] = '{1, 50, 0, 0};
        scenario(0, 0);
        att[0] = '{2, 30, 0, 10};
        att[1] = '{2, 30, 0, 0};
        scenario(0, 0);
        for (int i = 0; i < 4; i++) att[i] = '{1000, 1, 0, 0};
        scenario(0, 0);
        att[0] = '{3, 20, 0, 23};
        att[1] = '{1, 10, 2, 0};
        scenario(0, 0);
        att[0] = '{4, 15, 3, 0};
        scenario(1, 0);
        att[0] = '{2, 40, 0, 0};
        scenario(0, 1);
        for (int s = 0; s < 20; s++) begin
            for (int i = 0; i < 4; i++) att[i] = gen();
            scenario(1'($urandom_range(0, 1)), 0);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
